// File: rtl/spectro_pkg.sv
// Shared spectrogram geometry and the row/bin -> RAM bank/address mapping used
// by both the frame writer and the display read-address generator.
package spectro_pkg;

    localparam int NO_FFTS        = 50;
    localparam int FFT_SIZE       = 256;
    localparam int NO_BANKS       = 2;
    localparam int RAM_ADDR_WIDTH = 12;
    localparam int PIX_W          = 4;
    localparam int FFT_IDX_WIDTH  = $clog2(NO_FFTS);
    localparam int BIN_IDX_WIDTH  = $clog2(FFT_SIZE);
    localparam int HALF_BIN_WIDTH = $clog2(FFT_SIZE / 2);

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_SKIP   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_RESYNC = 2'd3;

    // Rows with index MSB clear live in bank 0, the rest in bank 1.
    function automatic logic [NO_BANKS-1:0] row_bank_select(
        input logic [FFT_IDX_WIDTH-1:0] idx
    );
        return idx[FFT_IDX_WIDTH-1] ? NO_BANKS'(2) : NO_BANKS'(1);
    endfunction

    function automatic logic [RAM_ADDR_WIDTH-1:0] row_bin_address(
        input logic [FFT_IDX_WIDTH-1:0] idx,
        input logic [BIN_IDX_WIDTH-1:0] bin
    );
        return RAM_ADDR_WIDTH'({idx[FFT_IDX_WIDTH-2:0], bin[HALF_BIN_WIDTH-1:0]});
    endfunction

endpackage

// File: rtl/mag_quantizer.sv
// Combinational magnitude-to-pixel quantiser. Linear shift-and-saturate by
// default; log2 scale when FFT_WRITER_LOG_SCALE_EN is defined.
module mag_quantizer #(
    parameter int DATA_W    = 16,
    parameter int PIX_W     = 4,
    parameter int MAG_SHIFT = 8
) (
    input  logic [DATA_W-1:0] i_mag,
    output logic [PIX_W-1:0]  o_pix
);

    localparam int PIX_MAX = (1 << PIX_W) - 1;

`ifdef FFT_WRITER_LOG_SCALE_EN
    logic [31:0] w_msb_pos;

    // Highest set bit wins; zero input leaves position 0, same as input 1.
    always_comb begin
        w_msb_pos = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i_mag[i]) begin
                w_msb_pos = 32'(i);
            end
        end
    end

    assign o_pix = (w_msb_pos > 32'(PIX_MAX)) ? PIX_W'(PIX_MAX) : w_msb_pos[PIX_W-1:0];
`else
    logic [DATA_W-1:0] w_shifted;

    assign w_shifted = i_mag >> MAG_SHIFT;
    assign o_pix     = (w_shifted > DATA_W'(PIX_MAX)) ? PIX_W'(PIX_MAX) : w_shifted[PIX_W-1:0];
`endif

endmodule

// File: rtl/fft_frame_writer.sv
// Writes the lower half of each FFT frame as pixels into a circular spectrogram
// RAM, overwriting the oldest row. Build option: FFT_WRITER_LOG_SCALE_EN.
module fft_frame_writer
    import spectro_pkg::ST_FILL, spectro_pkg::ST_SKIP, spectro_pkg::ST_COMMIT, spectro_pkg::ST_RESYNC;
#(
    parameter int NO_BANKS       = 2,
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int NO_FFTS        = 50,
    parameter int FFT_SIZE       = 256,
    parameter int DATA_W         = 16,
    parameter int PIX_W          = 4,
    parameter int MAG_SHIFT      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_last,
    output logic                        wr_en,
    output logic [NO_BANKS-1:0]         wr_bank_select,
    output logic [RAM_ADDR_WIDTH-1:0]   wr_address,
    output logic [PIX_W-1:0]            wr_data,
    output logic [$clog2(NO_FFTS)-1:0]  oldest_fft_idx,
    output logic                        frame_done,
    output logic                        frame_err
);

    localparam int IDX_W  = $clog2(NO_FFTS);
    localparam int BIN_W  = $clog2(FFT_SIZE);
    localparam int HALF_W = $clog2(FFT_SIZE / 2);

    localparam logic [BIN_W-1:0] LAST_FILL_BIN = BIN_W'(FFT_SIZE / 2 - 1);
    localparam logic [BIN_W-1:0] LAST_BIN      = BIN_W'(FFT_SIZE - 1);
    localparam logic [IDX_W-1:0] LAST_ROW      = IDX_W'(NO_FFTS - 1);

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [BIN_W-1:0]          r_bin_cnt;
    logic [BIN_W-1:0]          w_bin_cnt_next;
    logic [IDX_W-1:0]          r_oldest;
    logic                      r_wr_en;
    logic [NO_BANKS-1:0]       r_wr_bank;
    logic [RAM_ADDR_WIDTH-1:0] r_wr_addr;
    logic [PIX_W-1:0]          r_wr_data;
    logic                      r_frame_done;
    logic                      r_frame_err;

    logic                      w_hs;
    logic                      w_write;
    logic                      w_err;
    logic [PIX_W-1:0]          w_pix;
    logic [NO_BANKS-1:0]       w_bank_sel;
    logic [RAM_ADDR_WIDTH-1:0] w_addr;

    assign s_ready = (r_state != ST_COMMIT);
    assign w_hs    = s_valid & s_ready;
    assign w_write = w_hs && (r_state == ST_FILL);

    mag_quantizer #(
        .DATA_W    (DATA_W),
        .PIX_W     (PIX_W),
        .MAG_SHIFT (MAG_SHIFT)
    ) u_quant (
        .i_mag (s_data),
        .o_pix (w_pix)
    );

    // Bank is chosen by the row index MSB; remaining row bits plus the
    // half-frame bin index form the word address inside that bank.
    genvar gi;
    generate
        for (gi = 0; gi < NO_BANKS; gi++) begin : g_bank
            assign w_bank_sel[gi] = ({31'd0, r_oldest[IDX_W-1]} == 32'(gi));
        end
    endgenerate

    assign w_addr = RAM_ADDR_WIDTH'({r_oldest[IDX_W-2:0], r_bin_cnt[HALF_W-1:0]});

    always_comb begin
        w_state_next   = r_state;
        w_bin_cnt_next = r_bin_cnt;
        w_err          = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_hs) begin
                    if (s_last) begin
                        w_err          = 1'b1;
                        w_bin_cnt_next = '0;
                    end else begin
                        w_bin_cnt_next = r_bin_cnt + 1'b1;
                        if (r_bin_cnt == LAST_FILL_BIN) begin
                            w_state_next = ST_SKIP;
                        end
                    end
                end
            end
            ST_SKIP: begin
                if (w_hs) begin
                    if (r_bin_cnt == LAST_BIN) begin
                        w_bin_cnt_next = '0;
                        if (s_last) begin
                            w_state_next = ST_COMMIT;
                        end else begin
                            w_err        = 1'b1;
                            w_state_next = ST_RESYNC;
                        end
                    end else if (s_last) begin
                        w_err          = 1'b1;
                        w_bin_cnt_next = '0;
                        w_state_next   = ST_FILL;
                    end else begin
                        w_bin_cnt_next = r_bin_cnt + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                w_state_next   = ST_FILL;
                w_bin_cnt_next = '0;
            end
            ST_RESYNC: begin
                if (w_hs && s_last) begin
                    w_state_next   = ST_FILL;
                    w_bin_cnt_next = '0;
                end
            end
            default: begin
                w_state_next   = ST_FILL;
                w_bin_cnt_next = '0;
            end
        endcase
    end

    // The row index advances on entry to COMMIT so it is already updated
    // while frame_done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_bin_cnt    <= '0;
            r_oldest     <= '0;
            r_wr_en      <= 1'b0;
            r_wr_bank    <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bin_cnt    <= w_bin_cnt_next;
            r_frame_done <= (w_state_next == ST_COMMIT);
            r_frame_err  <= w_err;
            r_wr_en      <= w_write;
            if (w_state_next == ST_COMMIT) begin
                r_oldest <= (r_oldest == LAST_ROW) ? '0 : r_oldest + 1'b1;
            end
            if (w_write) begin
                r_wr_bank <= w_bank_sel;
                r_wr_addr <= w_addr;
                r_wr_data <= w_pix;
            end
        end
    end

    assign wr_en          = r_wr_en;
    assign wr_bank_select = r_wr_bank;
    assign wr_address     = r_wr_addr;
    assign wr_data        = r_wr_data;
    assign oldest_fft_idx = r_oldest;
    assign frame_done     = r_frame_done;
    assign frame_err      = r_frame_err;

endmodule

// File: tb/tb_fft_frame_writer.sv
// Directed scoreboard bench for fft_frame_writer: expected RAM writes are queued
// as bins are driven and popped as the DUT emits them.
module tb_fft_frame_writer;

    typedef struct packed {
        logic [1:0]  bank;
        logic [11:0] addr;
        logic [3:0]  data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        wr_en;
    logic [1:0]  wr_bank_select;
    logic [11:0] wr_address;
    logic [3:0]  wr_data;
    logic [5:0]  oldest_fft_idx;
    logic        frame_done;
    logic        frame_err;

    int  checks   = 0;
    int  errors   = 0;
    int  done_cnt = 0;
    int  err_cnt  = 0;
    int  exp_done = 0;
    int  exp_err  = 0;
    int  m_oldest = 0;
    int  frame_no = 0;
    wr_t exp_q[$];

    fft_frame_writer dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .wr_en          (wr_en),
        .wr_bank_select (wr_bank_select),
        .wr_address     (wr_address),
        .wr_data        (wr_data),
        .oldest_fft_idx (oldest_fft_idx),
        .frame_done     (frame_done),
        .frame_err      (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_pix(input logic [15:0] d);
`ifdef FFT_WRITER_LOG_SCALE_EN
        int p;
        p = 0;
        if (d == 16'd0) return 4'd0;
        while ((d >> (p + 1)) != 16'd0) p++;
        return (p > 15) ? 4'd15 : 4'(p);
`else
        logic [15:0] s;
        s = d >> 8;
        return (s > 16'd15) ? 4'd15 : s[3:0];
`endif
    endfunction

    function automatic logic [15:0] bin_data(input int pat, input int i);
        case (pat)
            0: return 16'h0A00;
            1: return 16'h1234;
            2: return 16'(i << 8);
            3: case (i % 4)
                   0: return 16'h0100;
                   1: return 16'h0000;
                   2: return 16'hFFFF;
                   default: return 16'h0A00;
               endcase
            default: return 16'($urandom);
        endcase
    endfunction

    // Output side of the scoreboard plus pulse counters.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (frame_done) begin
            done_cnt++;
            check("commit_ready_low", 32'(s_ready), 32'd0);
        end
        if (frame_err) err_cnt++;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(wr_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_bank", 32'(wr_bank_select), 32'(e.bank));
                check("wr_addr", 32'(wr_address), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        while (s_ready !== 1'b1 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (s_ready !== 1'b1) check("ready_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic push_write(input int bin, input logic [15:0] d);
        wr_t e;
        e.bank = (m_oldest >= 32) ? 2'b10 : 2'b01;
        e.addr = 12'((m_oldest % 32) * 128 + bin);
        e.data = model_pix(d);
        exp_q.push_back(e);
    endtask

    task automatic run_frame(input int nbins, input logic last_on_end, input int pat, input logic do_write);
        logic [15:0] d;
        for (int i = 0; i < nbins; i++) begin
            d = bin_data(pat, i);
            if (do_write && i < 128) push_write(i, d);
            send(d, last_on_end && (i == nbins - 1));
            if (i % 53 == 17) idle(1);
        end
    endtask

    task automatic full_frame(input int pat);
        run_frame(256, 1'b1, pat, 1'b1);
        m_oldest = (m_oldest + 1) % 50;
        exp_done++;
        idle(2);
        frame_no++;
        $display("frame %0d pat=%0d oldest=%0d done=%0d pending=%0d", frame_no, pat,
                 oldest_fft_idx, done_cnt, exp_q.size());
        check("frame_done_count", 32'(done_cnt), 32'(exp_done));
        check("oldest_after_frame", 32'(oldest_fft_idx), 32'(m_oldest));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_bank", 32'(wr_bank_select), 32'd0);
        check("rst_addr", 32'(wr_address), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_oldest", 32'(oldest_fft_idx), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        rst = 1'b0;
        idle(1);

        // First frame: constant 0x0A00 -> row 0, bank 01, oldest becomes 1.
        full_frame(0);
        full_frame(1);
        full_frame(3);
        full_frame(2);
        while (m_oldest < 32) full_frame(4);
        check("oldest_before_bank1", 32'(oldest_fft_idx), 32'd32);
        full_frame(0);
        while (m_oldest != 0) full_frame(4);
        check("oldest_wrapped", 32'(oldest_fft_idx), 32'd0);

        // Early s_last at bin 100: error, row kept, next frame rewrites it.
        run_frame(101, 1'b1, 0, 1'b1);
        exp_err++;
        idle(2);
        $display("early_last err=%0d oldest=%0d", err_cnt, oldest_fft_idx);
        check("early_last_err", 32'(err_cnt), 32'(exp_err));
        check("early_last_oldest", 32'(oldest_fft_idx), 32'(m_oldest));
        full_frame(3);

        // Missing s_last at bin 255, then three resync bins ending in s_last.
        run_frame(256, 1'b0, 1, 1'b1);
        run_frame(3, 1'b1, 0, 1'b0);
        exp_err++;
        idle(2);
        $display("resync err=%0d done=%0d", err_cnt, done_cnt);
        check("resync_err", 32'(err_cnt), 32'(exp_err));
        check("resync_no_commit", 32'(done_cnt), 32'(exp_done));
        check("resync_oldest", 32'(oldest_fft_idx), 32'(m_oldest));
        full_frame(0);

        // Reset while bin 60 is being presented.
        run_frame(60, 1'b0, 2, 1'b1);
        s_valid = 1'b1;
        s_data  = 16'hFFFF;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_oldest = 0;
        idle(2);
        $display("mid_frame_reset oldest=%0d done=%0d err=%0d", oldest_fft_idx, done_cnt, err_cnt);
        check("reset_oldest", 32'(oldest_fft_idx), 32'd0);
        check("reset_no_done", 32'(done_cnt), 32'(exp_done));
        check("reset_no_err", 32'(err_cnt), 32'(exp_err));
        check("reset_queue", 32'(exp_q.size()), 32'd0);
        full_frame(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
